// File: rtl/sram_mem_controller_if.sv
// MEM-stage data-memory request bus plus the external SRAM pin group.
// Latency: n/a (signal bundle only).
// Backpressure: ready low stalls the requester; rd_en/wr_en are levels held until ready=1.
//
// Signals:
//   rd_en, wr_en, address, write_data : request from the MEM stage
//   read_data, ready                  : response to the MEM stage
//   sram_addr, sram_dq_out, sram_dq_oe, sram_we_n : controller-driven SRAM pins
//   sram_dq_in                        : data returned by the SRAM
interface sram_mem_controller_if #(
    parameter int SRAM_AW = 18
) ();
    logic               rd_en;
    logic               wr_en;
    logic [31:0]        address;
    logic [31:0]        write_data;
    logic [31:0]        read_data;
    logic               ready;
    logic [SRAM_AW-1:0] sram_addr;
    logic [15:0]        sram_dq_out;
    logic [15:0]        sram_dq_in;
    logic               sram_dq_oe;
    logic               sram_we_n;

    // Requester side (MEM stage and board SRAM model).
    modport master (
        output rd_en, wr_en, address, write_data, sram_dq_in,
        input  read_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
    );

    // Controller side.
    modport slave (
        input  rd_en, wr_en, address, write_data, sram_dq_in,
        output read_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
    );
endinterface

// File: rtl/sram_mem_controller.sv
// Performs one 32-bit MEM-stage load/store as two 16-bit SRAM accesses (low half, then high half).
// Latency: request seen in IDLE at cycle 0 completes (ready=1) at cycle 2*WAIT_CYCLES+3.
// Backpressure: ready drops combinationally in the cycle a request appears and stays low until DONE.
//
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : sram_mem_controller_if.slave (MEM-stage request/response and SRAM pins)
module sram_mem_controller #(
    parameter int BASE_ADDR   = 1024,
    parameter int WAIT_CYCLES = 1,
    parameter int SRAM_AW     = 18
) (
    input  logic                  clk,
    input  logic                  rst,
    sram_mem_controller_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [2:0] WAIT_LAST = 3'(WAIT_CYCLES);

    state_t             state, state_nxt;
    logic [2:0]         wait_cnt, wait_cnt_nxt;
    logic               req;
    logic               last;
    logic               ready;

    logic [SRAM_AW-2:0] req_word;
    logic [SRAM_AW-2:0] lat_word;
    logic [31:0]        lat_data;
    logic               lat_wr;

    // Source for the SRAM pin registers: live request inputs on the IDLE->LO
    // edge (latches not yet loaded), latched copies afterwards.
    logic [SRAM_AW-2:0] cur_word;
    logic [31:0]        cur_data;
    logic               cur_wr;

    logic [31:0]        read_data_q;
    logic [SRAM_AW-1:0] sram_addr_q;
    logic [15:0]        sram_dq_out_q;
    logic               sram_dq_oe_q;
    logic               sram_we_n_q;

    assign req  = bus.rd_en | bus.wr_en;
    assign last = (wait_cnt == WAIT_LAST);

    // Word index wraps silently modulo the SRAM size.
    assign req_word = (SRAM_AW-1)'((bus.address - 32'(BASE_ADDR)) >> 2);

    assign cur_word = (state == IDLE) ? req_word      : lat_word;
    assign cur_data = (state == IDLE) ? bus.write_data : lat_data;
    assign cur_wr   = (state == IDLE) ? bus.wr_en      : lat_wr;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            wait_cnt <= 3'd0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        ready        = 1'b0;
        case (state)
            IDLE: begin
                ready = ~req;
                if (req) begin
                    state_nxt    = LO;
                    wait_cnt_nxt = 3'd0;
                end
            end
            LO: begin
                if (last) begin
                    state_nxt    = HI;
                    wait_cnt_nxt = 3'd0;
                end else begin
                    wait_cnt_nxt = wait_cnt + 3'd1;
                end
            end
            HI: begin
                if (last) begin
                    state_nxt    = DONE;
                    wait_cnt_nxt = 3'd0;
                end else begin
                    wait_cnt_nxt = wait_cnt + 3'd1;
                end
            end
            DONE: begin
                // The pipeline advances on this edge; the still-visible
                // request is deliberately not re-accepted.
                ready     = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ----------------------------------------------------------- datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_word      <= '0;
            lat_data      <= '0;
            lat_wr        <= 1'b0;
            read_data_q   <= '0;
            sram_addr_q   <= '0;
            sram_dq_out_q <= '0;
            sram_dq_oe_q  <= 1'b0;
            sram_we_n_q   <= 1'b1;
        end else begin
            if (state == IDLE && req) begin
                lat_word <= req_word;
                lat_data <= bus.write_data;
                lat_wr   <= bus.wr_en;
            end

            // Pins are registered from the next state so they are valid for
            // the whole of every LO/HI cycle; address and data hold outside.
            case (state_nxt)
                LO: begin
                    sram_addr_q   <= {cur_word, 1'b0};
                    sram_dq_out_q <= cur_data[15:0];
                    sram_dq_oe_q  <= cur_wr;
                    sram_we_n_q   <= ~cur_wr;
                end
                HI: begin
                    sram_addr_q   <= {cur_word, 1'b1};
                    sram_dq_out_q <= cur_data[31:16];
                    sram_dq_oe_q  <= cur_wr;
                    sram_we_n_q   <= ~cur_wr;
                end
                default: begin
                    sram_dq_oe_q <= 1'b0;
                    sram_we_n_q  <= 1'b1;
                end
            endcase

            // Capture at the end of the final wait-state cycle of each half.
            if (!lat_wr && last) begin
                if (state == LO) read_data_q[15:0]  <= bus.sram_dq_in;
                if (state == HI) read_data_q[31:16] <= bus.sram_dq_in;
            end
        end
    end

    assign bus.ready       = ready;
    assign bus.read_data   = read_data_q;
    assign bus.sram_addr   = sram_addr_q;
    assign bus.sram_dq_out = sram_dq_out_q;
    assign bus.sram_dq_oe  = sram_dq_oe_q;
    assign bus.sram_we_n   = sram_we_n_q;

endmodule

// File: doc/sram_mem_controller.md
Name: sram_mem_controller

Overview:
- Responder side of the MEM-stage data-memory interface: accepts one 32-bit read or write request from the MEM stage and performs it as two 16-bit accesses on an external SRAM.
- Lowers `ready` while busy; the top level drives pipeline `freeze` = ~ready.
- Sits between MEM_Stage_Module and the board SRAM pins.

Parameters:
- BASE_ADDR, 1024: pipeline byte address that maps to SRAM word 0.
- WAIT_CYCLES, 1: extra SRAM wait states per 16-bit half-access (0..7).
- SRAM_AW, 18: SRAM half-word address width.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- rd_en  input  1  MEM-stage read request; level, held until ready=1.
- wr_en  input  1  MEM-stage write request; level, held until ready=1.
- address  input  32  byte address from the MEM stage.
- write_data  input  32  store data.
- read_data  output  32  load data; valid in the ready=1 cycle of a read.
- ready  output  1  1 = no access in flight, or access completing this cycle.
- sram_addr  output  SRAM_AW  SRAM half-word address.
- sram_dq_out  output  16  SRAM write data.
- sram_dq_in  input  16  SRAM read data.
- sram_dq_oe  output  1  1 = controller drives the DQ bus.
- sram_we_n  output  1  active-low SRAM write strobe.

Behaviour:
- Address mapping:
  - word = (address − BASE_ADDR) >> 2, truncated to SRAM_AW−1 bits; wraps modulo 2^(SRAM_AW−1), with no error.
  - sram_addr = {word, half}; half=0 selects bits [15:0], half=1 selects bits [31:16].
- Request decode:
  - wr_en=1 means write, regardless of rd_en; a simultaneous rd_en and wr_en is treated as a write.
  - wr_en=0 with rd_en=1 means read.
- FSM states: IDLE, LO, HI, DONE.
  - IDLE: on a request, latch address, write_data and the read/write flag, clear the wait counter, and go to LO. Otherwise stay in IDLE.
  - LO: stay WAIT_CYCLES+1 cycles with half=0, then go to HI with the counter cleared.
  - HI: stay WAIT_CYCLES+1 cycles with half=1, then go to DONE.
  - DONE: one cycle, then IDLE.
- `ready` (combinational):
  - 1 in IDLE with no request.
  - 1 in DONE.
  - 0 in every other case, including the IDLE cycle in which a request first appears, so the freeze takes effect the same cycle.
- Latency:
  - A request first seen in IDLE at cycle 0 gives DONE (ready=1) at cycle 2·WAIT_CYCLES+3.
  - ready is low for 2·WAIT_CYCLES+3 cycles.
- Pipeline interaction:
  - The pipeline advances on the DONE edge. The request still visible in DONE is not re-accepted.
  - A new request present in the following IDLE cycle starts a new access immediately (back-to-back).
- Inputs while busy: address, write_data, rd_en and wr_en are ignored during LO/HI/DONE; the latched copies are used.
- Writes:
  - sram_dq_oe=1 and sram_we_n=0 for every LO/HI cycle.
  - sram_dq_out = latched data[15:0] in LO and latched data[31:16] in HI.
- Reads:
  - sram_dq_oe=0 and sram_we_n=1.
  - sram_dq_in is sampled on the last cycle of LO into read_data[15:0] and on the last cycle of HI into read_data[31:16].
  - read_data holds its value until the next read overwrites it; writes do not alter it.
- Outside LO/HI: sram_we_n=1, sram_dq_oe=0, and sram_addr and sram_dq_out hold their last values.
- Reset (any time, including mid-access):
  - State goes to IDLE immediately.
  - read_data=0, sram_addr=0, sram_dq_out=0, sram_dq_oe=0, sram_we_n=1, wait counter=0.
  - ready becomes 1 if no request is present.
  - An interrupted write may have updated the low half only; this is acceptable.

Test Plan:
- Read, WAIT_CYCLES=1:
  - Stimulus: SRAM model holds 0xBEEF at half-address 4 and 0xDEAD at half-address 5; rd_en=1, address=1032 at cycle 0.
  - Required: ready=0 on cycles 0–4; sram_addr=4 on cycles 1–2 and 5 on cycles 3–4; cycle 5 ready=1 with read_data=0xDEADBEEF.
- Write:
  - Stimulus: wr_en=1, address=1024, write_data=0x12345678.
  - Required: sram_we_n=0 and dq_out=0x5678 at sram_addr 0 for two cycles, then dq_out=0x1234 at sram_addr 1 for two cycles; ready=1 at cycle 5; a subsequent read of 1024 returns 0x12345678.
- Back-to-back:
  - Stimulus: write to 1028 completes, and the next cycle presents rd_en at 1028.
  - Required: the new access starts in that IDLE cycle; the read returns the written value; there is no idle gap beyond the single IDLE cycle.
- Simultaneous rd_en=1 and wr_en=1:
  - Required: a write is performed (sram_we_n pulses low); read_data is unchanged.
- Reset mid-write:
  - Stimulus: assert rst during HI.
  - Required: sram_we_n=1, dq_oe=0, state IDLE and read_data=0 immediately (asynchronously); after rst is released with no request, ready=1.
- WAIT_CYCLES=0, read of 1036:
  - Required: ready=0 for exactly 3 cycles; sram_addr 6 then 7; correct 32-bit assembly in read_data.
